// File: rtl/adder_sum_accumulator_if.sv
// adder_sum_accumulator_if: sample-in / block-out handshake bundle for adder_sum_accumulator
interface adder_sum_accumulator_if #(parameter int ACC_WIDTH = 12);
  logic                 in_valid;
  logic [3:0]           in_sum;
  logic                 in_c;
  logic                 in_flush;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [7:0]           out_count;
  logic                 out_ovf;
  modport master (
    output in_valid, in_sum, in_c, in_flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_sum, in_c, in_flush, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: sums blocks of 5-bit adder results; ADDER_ACC_SATURATE_EN clamps instead of wrapping
module adder_sum_accumulator #(
  parameter int ACC_WIDTH = 12,
  parameter int BLOCK_LEN = 8
) (
  input logic clk,
  input logic rst,
  adder_sum_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_e;
  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;
  logic [7:0]           count_q, count_d;
  logic                 ovf_q, ovf_d, accept, carry, close;
  assign accept = bus.in_valid & bus.in_ready;
  // next running total; a flush counts the same-cycle sample before closing the block
  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_WIDTH-4){1'b0}}, bus.in_c, bus.in_sum};
    carry   = sum[ACC_WIDTH];
`ifdef ADDER_ACC_SATURATE_EN
    acc_d   = accept ? (carry ? '1 : sum[ACC_WIDTH-1:0]) : acc_q;
`else
    acc_d   = accept ? sum[ACC_WIDTH-1:0] : acc_q;
`endif
    count_d = count_q + {7'd0, accept};
    ovf_d   = ovf_q | (accept & carry);
    close   = (accept & (count_d == 8'(BLOCK_LEN))) | (bus.in_flush & (count_d != 8'd0));
  end
  // block FSM: accumulate until full or flushed, then hold the result until the sink takes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == HOLD) begin
      if (bus.out_ready) begin
        state_q <= ACCUM;
        acc_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (close) state_q <= HOLD;
    end
  end
  assign bus.in_ready  = rst & (state_q == ACCUM);
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_acc   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb_adder_sum_accumulator: three configurations driven in lockstep against a block-list reference model
module tb_adder_sum_accumulator;
  logic clk = 1'b0, rst = 1'b0, v = 1'b0, f = 1'b0, ordy = 1'b0;
  logic [4:0] s = 5'd0;
  int n_vec = 0, n_err = 0;
`ifdef ADDER_ACC_SATURATE_EN
  localparam int OVF_ACC = 63;
`else
  localparam int OVF_ACC = 60;
`endif
  always #5 clk = ~clk;
  adder_sum_accumulator_if #(.ACC_WIDTH(12)) b0();
  adder_sum_accumulator_if #(.ACC_WIDTH(6))  b1();
  adder_sum_accumulator_if #(.ACC_WIDTH(12)) b2();
  adder_sum_accumulator #(.ACC_WIDTH(12), .BLOCK_LEN(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  adder_sum_accumulator #(.ACC_WIDTH(6),  .BLOCK_LEN(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  adder_sum_accumulator #(.ACC_WIDTH(12), .BLOCK_LEN(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  assign {b0.in_valid, b0.in_c, b0.in_sum, b0.in_flush, b0.out_ready} = {v, s, f, ordy};
  assign {b1.in_valid, b1.in_c, b1.in_sum, b1.in_flush, b1.out_ready} = {v, s, f, ordy};
  assign {b2.in_valid, b2.in_c, b2.in_sum, b2.in_flush, b2.out_ready} = {v, s, f, ordy};
  logic [31:0] o_acc[3];
  logic [7:0]  o_cnt[3];
  logic        o_vld[3], o_rdy[3], o_ovf[3];
  assign o_acc[0] = 32'(b0.out_acc);
  assign o_acc[1] = 32'(b1.out_acc);
  assign o_acc[2] = 32'(b2.out_acc);
  assign {o_cnt[0], o_vld[0], o_rdy[0], o_ovf[0]} = {b0.out_count, b0.out_valid, b0.in_ready, b0.out_ovf};
  assign {o_cnt[1], o_vld[1], o_rdy[1], o_ovf[1]} = {b1.out_count, b1.out_valid, b1.in_ready, b1.out_ovf};
  assign {o_cnt[2], o_vld[2], o_rdy[2], o_ovf[2]} = {b2.out_count, b2.out_valid, b2.in_ready, b2.out_ovf};
  // reference model: the samples of the open block and whether it is waiting for the sink
  int wid[3] = '{12, 6, 12};
  int len[3] = '{8, 4, 1};
  int blk[3][$];
  bit hold[3];
  task automatic model_total(input int k, output int t, output bit o);
    int mx;
    mx = (1 << wid[k]) - 1;
    t = 0;
    o = 1'b0;
    for (int i = 0; i < blk[k].size(); i++) begin
      t += blk[k][i];
      if (t > mx) begin
        o = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
        t = mx;
`else
        t -= mx + 1;
`endif
      end
    end
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // one clock: drive, step the model at the edge, compare on the falling edge
  task automatic cyc(input logic r_i, input logic v_i, input int smp, input logic f_i, input logic o_i);
    rst = r_i;
    v = v_i;
    s = 5'(smp);
    f = f_i;
    ordy = o_i;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!r_i) begin
        blk[k].delete();
        hold[k] = 1'b0;
      end else if (hold[k]) begin
        if (o_i) begin
          hold[k] = 1'b0;
          blk[k].delete();
        end
      end else begin
        if (v_i) blk[k].push_back(smp & 31);
        if ((v_i && blk[k].size() == len[k]) || (f_i && blk[k].size() > 0)) hold[k] = 1'b1;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      int t;
      bit o;
      model_total(k, t, o);
      check($sformatf("in_ready%0d", k), 32'(o_rdy[k]), 32'(r_i & !hold[k]));
      check($sformatf("out_valid%0d", k), 32'(o_vld[k]), 32'(hold[k]));
      if (hold[k] || blk[k].size() == 0) begin
        check($sformatf("out_acc%0d", k), o_acc[k], 32'(t));
        check($sformatf("out_count%0d", k), 32'(o_cnt[k]), 32'(blk[k].size()));
        check($sformatf("out_ovf%0d", k), 32'(o_ovf[k]), 32'(o));
      end
    end
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 31, 0, 0);
      if (i == 3) begin
        check("ovf_acc", o_acc[1], OVF_ACC);
        check("ovf_flag", 32'(o_ovf[1]), 1);
      end
    end
    check("blk_acc", o_acc[0], 248);
    check("blk_cnt", 32'(o_cnt[0]), 8);
    check("blk_ovf", 32'(o_ovf[0]), 0);
    check("blk_vld", 32'(o_vld[0]), 1);
    repeat (5) cyc(1, 1, 9, 0, 0);
    check("bp_acc", o_acc[0], 248);
    check("bp_rdy", 32'(o_rdy[0]), 0);
    cyc(1, 1, 9, 0, 1);
    check("hs_rdy", 32'(o_rdy[0]), 1);
    check("hs_cnt", 32'(o_cnt[0]), 0);
    cyc(1, 1, 5, 0, 1);
    cyc(1, 1, 7, 0, 1);
    cyc(1, 1, 2, 0, 1);
    cyc(1, 1, 10, 1, 1);
    check("flush_acc", o_acc[0], 24);
    check("flush_cnt", 32'(o_cnt[0]), 4);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1);
    check("flush_empty", 32'(o_vld[0]), 0);
    repeat (5) cyc(1, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_vld", 32'(o_vld[0]), 0);
    check("rst_cnt", 32'(o_cnt[0]), 0);
    check("rst_rdy", 32'(o_rdy[0]), 0);
    repeat (8) cyc(1, 1, 4, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    check("hold_vld", 32'(o_vld[0]), 1);
    cyc(0, 0, 0, 0, 0);
    check("rst_hold_vld", 32'(o_vld[0]), 0);
    repeat (8) cyc(1, 1, 2, 0, 1);
    check("post_rst_acc", o_acc[0], 16);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, i + 3, 0, 1);
      check("stream_vld", 32'(o_vld[2]), 32'(i % 2 == 0));
      if (i % 2 == 0) begin
        check("stream_acc", o_acc[2], i + 3);
        check("stream_cnt", 32'(o_cnt[2]), 1);
      end
    end
    repeat (3000)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
          $urandom_range(0, 7) == 0, $urandom_range(0, 4) < 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
